// File: rtl/timer_bcd_converter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_bcd_converter_pkg                                               |
// | Shared state encoding and constants for the binary-to-BCD converter.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package timer_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int c_default_width  = 8;
  localparam int c_default_digits = 3;
  localparam int c_add3_threshold = 5;

endpackage
`default_nettype wire

// File: rtl/timer_bcd_converter_bcd_digit_adjust.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_adjust                                                      |
// | Double-dabble correction: adds 3 to a BCD digit of 5 or more.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bcd_digit_adjust
  import timer_bcd_converter_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'(c_add3_threshold)) ? (digit_in + 4'd3) : digit_in;

endmodule
`default_nettype wire

// File: rtl/timer_bcd_converter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_bcd_converter                                                   |
// | Sequential double-dabble converter for the countdown timer display.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module timer_bcd_converter
  import timer_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = c_default_width,
  parameter int DIGITS = c_default_digits
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Value,
  input  logic             Load,
  output logic             Busy,
  output logic             Valid,
  output logic [3:0]       Ones,
  output logic [3:0]       Tens,
  output logic [3:0]       Hundreds,
  output logic             BlankHundreds,
  output logic             BlankTens
);

  localparam int c_cnt_w      = $clog2(WIDTH + 1);
  localparam int c_ext_digits = (DIGITS < 3) ? 3 : DIGITS;
  localparam int c_ext_w      = 4 * c_ext_digits;

  state_t              r_state;
  state_t              w_next_state;
  logic [WIDTH-1:0]    r_shift;
  logic [WIDTH-1:0]    r_last;
  logic [4*DIGITS-1:0] r_scratch;
  logic [4*DIGITS-1:0] w_adj;
  logic [c_ext_w-1:0]  w_ext;
  logic [c_cnt_w-1:0]  r_count;
  logic                w_trigger;
  logic                w_last_shift;
  logic                r_valid;
  logic [3:0]          r_ones;
  logic [3:0]          r_tens;
  logic [3:0]          r_hundreds;
  logic                r_blank_h;
  logic                r_blank_t;

  assign w_trigger    = Load || (Value != r_last);
  assign w_last_shift = (r_count == c_cnt_w'(WIDTH - 1));
  // Zero-extend so Hundreds is defined even for a two-digit build.
  assign w_ext        = c_ext_w'(r_scratch);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (r_scratch[4*gi +: 4]),
      .digit_out (w_adj[4*gi +: 4])
    );
  end

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_next_state = SHIFT;
      SHIFT:   if (w_last_shift) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_shift    <= '0;
      r_last     <= '0;
      r_scratch  <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_ones     <= 4'd0;
      r_tens     <= 4'd0;
      r_hundreds <= 4'd0;
      r_blank_h  <= 1'b1;
      r_blank_t  <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_shift   <= Value;
            r_last    <= Value;
            r_scratch <= '0;
            r_count   <= '0;
          end
        end
        SHIFT: begin
          r_scratch <= {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_count   <= r_count + 1'b1;
        end
        DONE: begin
          // Only place the visible digits change, so no partial result leaks.
          r_ones     <= w_ext[3:0];
          r_tens     <= w_ext[7:4];
          r_hundreds <= w_ext[11:8];
          r_blank_h  <= (w_ext[11:8] == 4'd0);
          r_blank_t  <= (w_ext[11:8] == 4'd0) && (w_ext[7:4] == 4'd0);
          r_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy          = (r_state != IDLE);
  assign Valid         = r_valid;
  assign Ones          = r_ones;
  assign Tens          = r_tens;
  assign Hundreds      = r_hundreds;
  assign BlankHundreds = r_blank_h;
  assign BlankTens     = r_blank_t;

endmodule
`default_nettype wire

// File: doc/timer_bcd_converter.md
TIMER_BCD_CONVERTER -- requirements
Module: timer_bcd_converter

Interface
REQ-001 Parameter WIDTH, default 8, is the binary input width in bits.
REQ-002 Parameter DIGITS, default 3, is the number of BCD output digits; DIGITS SHALL be at least ceil(WIDTH*log10(2)).
REQ-003 Clock  input  1  rising-edge system clock.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Value  input  WIDTH  binary count from the countdown timer (unsigned).
REQ-006 Load  input  1  forces a conversion of Value even if it is unchanged.
REQ-007 Busy  output  1  high while a conversion is in progress.
REQ-008 Valid  output  1  one-cycle pulse when new digit outputs are presented.
REQ-009 Ones, Tens, Hundreds  output  4 each  registered BCD digits of the last converted Value.
REQ-010 BlankHundreds, BlankTens  output  1 each  registered leading-zero blank flags for the display stage.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-012 In IDLE, a trigger SHALL occur when Load=1 or Value != LastValue, where LastValue is the internal copy of the last captured Value.
REQ-013 On a trigger edge N: Value SHALL load into the shift register, LastValue <= Value, the BCD scratch register SHALL clear, state -> SHIFT, and Busy=1 from cycle N+1.
REQ-014 Each SHIFT cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one bit.
REQ-015 Exactly WIDTH SHIFT iterations SHALL occur, on edges N+1..N+WIDTH; edge N+WIDTH transitions to DONE.
REQ-016 On edge N+WIDTH+1 (DONE), Ones/Tens/Hundreds and the blank flags SHALL update, Valid SHALL go high for exactly one cycle, Busy SHALL go low, and state -> IDLE.
REQ-017 Latency for WIDTH=8 SHALL be 9 edges from the capture edge to the output-update edge; throughput is one conversion per 10 cycles.
REQ-018 Digit outputs SHALL hold their last values at all times except on the DONE edge; they SHALL never show intermediate scratch values.
REQ-019 Value changes while Busy SHALL be ignored for the current conversion; because LastValue differs, a new conversion SHALL trigger on the first IDLE cycle after DONE.
REQ-020 Load while Busy SHALL be ignored and not queued.
REQ-021 BlankHundreds = (Hundreds==0); BlankTens = (Hundreds==0 && Tens==0); Ones SHALL never blank.
REQ-022 For WIDTH=8, the maximum input 255 SHALL convert to 2,5,5; no digit SHALL exceed 9.
REQ-023 The IDLE trigger check and a simultaneous Load with a Value change SHALL produce a single conversion.

Reset
REQ-024 Reset SHALL force state IDLE, Busy=0, Valid=0, Ones=Tens=Hundreds=0, BlankHundreds=BlankTens=1, LastValue=0, and clear the scratch and shift registers.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no Valid pulse; after release, a nonzero Value SHALL trigger a fresh conversion.
REQ-026 Reset SHALL take priority over every trigger and state transition.

Structure
REQ-027 The shared package SHALL hold the state encoding, the default WIDTH and DIGITS constants, and the add-3 threshold constant (5).
REQ-028 A combinational sub-module bcd_digit_adjust (4-bit in, 4-bit out, add 3 if >= 5) SHALL be instantiated DIGITS times.
REQ-029 The Value input SHALL connect directly to the timer's 8-bit count; the digit outputs SHALL feed the existing seven-segment decoders.

Verification
REQ-030 Reset, then Value=30 -> Valid pulse 9 edges after the capture edge with Hundreds=0, Tens=3, Ones=0, BlankHundreds=1, BlankTens=0.
REQ-031 Value=255 -> 2,5,5 with both blank flags 0; Value=10 -> 0,1,0 with BlankHundreds=1.
REQ-032 Value held at 0 after reset -> no Valid pulse for 50 cycles; a one-cycle Load pulse -> single Valid with 0,0,0 and both blank flags 1.
REQ-033 Value 30 -> 29 on the third SHIFT cycle -> first Valid shows 3,0, then a second conversion's Valid shows 2,9; there is no output glitch between them.
REQ-034 Reset asserted at the fifth SHIFT cycle -> next cycle Busy=0, outputs 0, blanks 1, and no Valid pulse; Value stable at 30 after release -> normal conversion.
REQ-035 Countdown from 30 to 0 stepping every 20 cycles -> 31 Valid pulses, each matching a BCD reference model.
